// File: rtl/cu_host_pkg.sv
// Purpose: shared constants and types for the Q-learning control-unit host front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cu_host_pkg;

    // Register word addresses
    localparam int unsigned ADDR_CTRL        = 0;
    localparam int unsigned ADDR_STATUS      = 1;
    localparam int unsigned ADDR_MAX_STEP    = 2;
    localparam int unsigned ADDR_MAX_EPISODE = 3;
    localparam int unsigned ADDR_SEED        = 4;
    localparam int unsigned ADDR_CYCLES      = 5;
    localparam int unsigned ADDR_EPISODE     = 6;

    // CTRL write bits
    localparam int unsigned CTRL_TRAIN = 0;
    localparam int unsigned CTRL_INFER = 1;
    localparam int unsigned CTRL_ABORT = 2;
    localparam int unsigned CTRL_CLR   = 3;

    // STATUS read bits
    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_DONE     = 1;
    localparam int unsigned ST_ERR      = 2;
    localparam int unsigned ST_ABORTED  = 3;
    localparam int unsigned ST_CU_IDLE  = 4;
    localparam int unsigned ST_CU_STATE = 8;   // 5-bit field [12:8]

    localparam logic [15:0] SEED_RST_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_RUN     = 2'd1,
        H_RELEASE = 2'd2
    } host_state_e;

endpackage

// File: rtl/cu_host_if.sv
// Purpose: register file, run sequencer and cycle counter in front of the Q-learning control unit.
// Latency: CTRL write -> request level next cycle; bus read -> data one cycle later; completion -> irq one cycle after cu_idle.
// Backpressure: none; every bus access is accepted in the cycle it is strobed.
module cu_host_if
    import cu_host_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 3,
    parameter logic [15:0] SEED_RST = SEED_RST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    output logic              irq,
    output logic              cu_start,
    output logic              cu_active,
    output logic [15:0]       cu_max_step,
    output logic [15:0]       cu_max_episode,
    output logic [15:0]       cu_seed,
    input  logic              cu_finish,
    input  logic              cu_idle,
    input  logic [15:0]       cu_ec,
    input  logic [4:0]        cu_state
);

    host_state_e       state_q, state_d;
    logic              mode_q, mode_d;          // 1: inference run, 0: training run
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;
    logic              irq_q, irq_d;
    logic [31:0]       cycles_q, cycles_d;
    logic [15:0]       max_step_q, max_episode_q, seed_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q;

    logic ctrl_wr;
    logic wr_train, wr_infer, wr_abort, wr_clr;
    logic busy;
    logic cfg_wr;
    logic unused_wdata;

    assign ctrl_wr  = bus_wr && (bus_addr == ADDR_W'(ADDR_CTRL));
    assign wr_train = bus_wdata[CTRL_TRAIN];
    assign wr_infer = bus_wdata[CTRL_INFER];
    assign wr_abort = bus_wdata[CTRL_ABORT];
    assign wr_clr   = bus_wdata[CTRL_CLR];
    assign busy     = (state_q != H_IDLE);
    // Run parameters are frozen for the whole run so the control unit sees stable limits.
    assign cfg_wr   = bus_wr && !busy;

    assign unused_wdata = ^bus_wdata[DATA_W-1:16];

    // Host FSM next state, sticky status flags, cycle counter and completion pulse.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        done_d    = done_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        cycles_d  = cycles_q;
        irq_d     = 1'b0;

        // Clear first so that any flag set in the same cycle (completion, error) wins.
        if (ctrl_wr && wr_clr) begin
            done_d    = 1'b0;
            err_d     = 1'b0;
            aborted_d = 1'b0;
        end

        unique case (state_q)
            H_IDLE: begin
                if (ctrl_wr && (wr_train || wr_infer)) begin
                    if (wr_train && wr_infer) begin
                        err_d = 1'b1;
                    end else if (!cu_idle) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d    = wr_infer;
                        done_d    = 1'b0;
                        aborted_d = 1'b0;
                        cycles_d  = '0;
                        state_d   = H_RUN;
                    end
                end
            end
            H_RUN: begin
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (ctrl_wr && (wr_train || wr_infer)) begin
                    err_d = 1'b1;
                end
                if (ctrl_wr && wr_abort) begin
                    aborted_d = 1'b1;
                    state_d   = H_RELEASE;
                end else if (cu_finish) begin
                    state_d = H_RELEASE;
                end
            end
            H_RELEASE: begin
                if (cu_idle) begin
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = H_IDLE;
                end
            end
            default: begin
                state_d = H_IDLE;
            end
        endcase
    end

    // FSM and status register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= H_IDLE;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            irq_q     <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            irq_q     <= irq_d;
            cycles_q  <= cycles_d;
        end
    end

    // Run-parameter registers; a zero seed would lock the LFSR, so it is stored as 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_step_q    <= '0;
            max_episode_q <= '0;
            seed_q        <= SEED_RST;
        end else if (cfg_wr) begin
            if (bus_addr == ADDR_W'(ADDR_MAX_STEP)) begin
                max_step_q <= bus_wdata[15:0];
            end
            if (bus_addr == ADDR_W'(ADDR_MAX_EPISODE)) begin
                max_episode_q <= bus_wdata[15:0];
            end
            if (bus_addr == ADDR_W'(ADDR_SEED)) begin
                seed_q <= (bus_wdata[15:0] == 16'd0) ? 16'h0001 : bus_wdata[15:0];
            end
        end
    end

    // Read mux over current register values, so a same-cycle update is not yet visible.
    always_comb begin
        rdata_d = '0;
        case (bus_addr)
            ADDR_W'(ADDR_STATUS): begin
                rdata_d[ST_BUSY]              = busy;
                rdata_d[ST_DONE]              = done_q;
                rdata_d[ST_ERR]               = err_q;
                rdata_d[ST_ABORTED]           = aborted_q;
                rdata_d[ST_CU_IDLE]           = cu_idle;
                rdata_d[ST_CU_STATE +: 5]     = cu_state;
            end
            ADDR_W'(ADDR_MAX_STEP):    rdata_d[15:0] = max_step_q;
            ADDR_W'(ADDR_MAX_EPISODE): rdata_d[15:0] = max_episode_q;
            ADDR_W'(ADDR_SEED):        rdata_d[15:0] = seed_q;
            ADDR_W'(ADDR_CYCLES):      rdata_d[31:0] = cycles_q;
            ADDR_W'(ADDR_EPISODE):     rdata_d[15:0] = cu_ec;
            default:                   rdata_d       = '0;
        endcase
    end

    // Read data register holds its value until the next read; valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus_rd;
            if (bus_rd) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign bus_rdata      = rdata_q;
    assign bus_rvalid     = rvalid_q;
    assign irq            = irq_q;
    assign cu_start       = (state_q == H_RUN) && !mode_q;
    assign cu_active      = (state_q == H_RUN) &&  mode_q;
    assign cu_max_step    = max_step_q;
    assign cu_max_episode = max_episode_q;
    assign cu_seed        = seed_q;

endmodule

// File: tb/tb_cu_host_if.sv
// Purpose: randomized self-checking bench for cu_host_if with a read scoreboard and run-level reference model.
// Latency: model expects request next cycle after CTRL write, read data one cycle after strobe.
// Backpressure: none modelled; the bus never stalls.
module tb_cu_host_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wr, bus_rd;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_rvalid, irq, cu_start, cu_active;
    logic [15:0] cu_max_step, cu_max_episode, cu_seed;
    logic        cu_finish, cu_idle;
    logic [15:0] cu_ec;
    logic [4:0]  cu_state;

    int checks = 0;
    int errors = 0;

    cu_host_if dut (
        .clk(clk), .rst(rst),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .irq(irq), .cu_start(cu_start), .cu_active(cu_active),
        .cu_max_step(cu_max_step), .cu_max_episode(cu_max_episode), .cu_seed(cu_seed),
        .cu_finish(cu_finish), .cu_idle(cu_idle), .cu_ec(cu_ec), .cu_state(cu_state)
    );

    always #5 clk = ~clk;

    // Reference model: what the host block is doing, in run-level terms.
    bit          m_running, m_releasing, m_infer, m_done, m_err, m_aborted, m_irq;
    logic [31:0] m_cycles;
    logic [15:0] m_step, m_ep, m_seed;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            3'd1: v = {19'd0, cu_state, 3'd0, cu_idle, m_aborted, m_err, m_done,
                       (m_running || m_releasing)};
            3'd2: v = {16'd0, m_step};
            3'd3: v = {16'd0, m_ep};
            3'd4: v = {16'd0, m_seed};
            3'd5: v = m_cycles;
            3'd6: v = {16'd0, cu_ec};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled, then check outputs.
    task automatic tick();
        bit          busy, ctrl, tr, inf;
        bit          n_run, n_rel, n_inf, n_done, n_err, n_ab, n_irq;
        logic [31:0] n_cyc;
        logic [15:0] n_step, n_ep, n_seed;
        busy = m_running || m_releasing;
        ctrl = bus_wr && (bus_addr == 3'd0);
        tr = bus_wdata[0];
        inf = bus_wdata[1];
        n_run = m_running; n_rel = m_releasing; n_inf = m_infer;
        n_done = m_done; n_err = m_err; n_ab = m_aborted; n_irq = 1'b0;
        n_cyc = m_cycles; n_step = m_step; n_ep = m_ep; n_seed = m_seed;
        if (m_running && m_cycles != 32'hFFFF_FFFF) n_cyc = m_cycles + 1;
        if (ctrl && bus_wdata[3]) begin n_done = 0; n_err = 0; n_ab = 0; end
        if (bus_wr && !busy) begin
            if (bus_addr == 3'd2) n_step = bus_wdata[15:0];
            if (bus_addr == 3'd3) n_ep = bus_wdata[15:0];
            if (bus_addr == 3'd4) n_seed = (bus_wdata[15:0] == 0) ? 16'd1 : bus_wdata[15:0];
        end
        if (!busy) begin
            if (ctrl && tr && inf) n_err = 1;
            else if (ctrl && (tr || inf) && !cu_idle) n_err = 1;
            else if (ctrl && (tr || inf)) begin
                n_run = 1; n_inf = inf; n_done = 0; n_ab = 0; n_cyc = 0;
            end
        end else if (m_running) begin
            if (ctrl && (tr || inf)) n_err = 1;
            if (ctrl && bus_wdata[2]) begin n_ab = 1; n_run = 0; n_rel = 1; end
            else if (cu_finish) begin n_run = 0; n_rel = 1; end
        end else if (cu_idle) begin
            n_rel = 0; n_done = 1; n_irq = 1;
        end
        if (rst) begin
            n_run = 0; n_rel = 0; n_inf = 0; n_done = 0; n_err = 0; n_ab = 0; n_irq = 0;
            n_cyc = 0; n_step = 0; n_ep = 0; n_seed = 16'hACE1;
        end
        @(posedge clk);
        #1;
        m_running = n_run; m_releasing = n_rel; m_infer = n_inf; m_done = n_done;
        m_err = n_err; m_aborted = n_ab; m_irq = n_irq; m_cycles = n_cyc;
        m_step = n_step; m_ep = n_ep; m_seed = n_seed;
        chk("cu_start", {31'd0, cu_start}, {31'd0, m_running && !m_infer});
        chk("cu_active", {31'd0, cu_active}, {31'd0, m_running && m_infer});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("cu_max_step", {16'd0, cu_max_step}, {16'd0, m_step});
        chk("cu_max_episode", {16'd0, cu_max_episode}, {16'd0, m_ep});
        chk("cu_seed", {16'd0, cu_seed}, {16'd0, m_seed});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_exp_t e;
        bus_rd = 1'b1; bus_addr = a;
        e.addr = a;
        e.data = exp_rd(a);
        exp_q.push_back(e);
        tick();
        bus_rd = 1'b0;
    endtask

    // Control-unit model: start, run for len cycles, finish or abort, release after rel_dly.
    task automatic run_one(input bit infer, input int len, input int rel_dly,
                           input bit do_abort, input bit clr_at_end, input bit noise);
        wr(3'd0, infer ? 32'd2 : 32'd1);
        cu_idle = 1'b0;
        cu_state = 5'($urandom_range(1, 31));
        cu_ec = 16'($urandom);
        for (int i = 0; i < len; i++) begin
            if (noise && ($urandom_range(0, 3) == 0))
                rd(3'($urandom_range(1, 7)));
            else if (noise && ($urandom_range(0, 3) == 0))
                wr(3'($urandom_range(2, 4)), $urandom);
            else
                tick();
        end
        if (do_abort) begin
            wr(3'd0, 32'd4);
        end else begin
            cu_finish = 1'b1;
            tick();
            cu_finish = 1'b0;
        end
        for (int i = 0; i < rel_dly; i++) tick();
        cu_idle = 1'b1;
        cu_state = 5'd0;
        if (clr_at_end) wr(3'd0, 32'd8);
        else tick();
        tick();
        rd(3'd1);
        rd(3'd5);
    endtask

    // Scoreboard monitor: every read response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected got %h expected no response", bus_rdata);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_addr%0d", e.addr), bus_rdata, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; bus_wr = 0; bus_rd = 0; bus_addr = 0; bus_wdata = 0;
        cu_finish = 0; cu_idle = 1'b1; cu_ec = 16'd0; cu_state = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rvalid", {31'd0, bus_rvalid}, 32'd0);
        chk("reset_rdata", bus_rdata, 32'd0);
        for (int a = 0; a < 8; a++) rd(3'(a));

        // Training run with a zero seed and a 40-cycle run.
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd3);
        wr(3'd4, 32'd0);
        rd(3'd4);
        chk("seed_zero_maps_to_one", {16'd0, cu_seed}, 32'd1);
        run_one(1'b0, 39, 1, 1'b0, 1'b0, 1'b0);
        rd(3'd1);
        chk("status_after_train", exp_rd(3'd1), 32'h12);
        chk("cycles_after_train", m_cycles, 32'd40);

        // Inference run.
        run_one(1'b1, 17, 3, 1'b0, 1'b0, 1'b0);
        chk("cycles_after_infer", m_cycles, 32'd18);

        // Illegal starts and clear.
        wr(3'd0, 32'd3);
        tick();
        rd(3'd1);
        cu_idle = 1'b0;
        wr(3'd0, 32'd1);
        tick();
        rd(3'd1);
        cu_idle = 1'b1;
        wr(3'd0, 32'd8);
        rd(3'd1);

        // Parameter writes ignored mid-run, then abort.
        wr(3'd0, 32'd1);
        cu_idle = 1'b0;
        tick();
        wr(3'd3, 32'd99);
        rd(3'd3);
        wr(3'd0, 32'd1);
        rd(3'd1);
        wr(3'd0, 32'd4);
        rd(3'd1);
        tick();
        cu_idle = 1'b1;
        tick();
        tick();
        rd(3'd1);

        // CLR in the same cycle as completion.
        run_one(1'b1, 5, 2, 1'b1, 1'b1, 1'b0);

        // Reset mid-run; the control unit is also in reset so cu_idle is low.
        wr(3'd0, 32'd1);
        cu_idle = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(3'd1);
        rd(3'd5);
        cu_idle = 1'b1;
        tick();

        // Randomized runs with bus traffic during the run.
        for (int r = 0; r < 25; r++) begin
            wr(3'd2, $urandom);
            wr(3'd3, $urandom);
            wr(3'd4, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            run_one(1'($urandom), $urandom_range(0, 30), $urandom_range(0, 5),
                    ($urandom_range(0, 3) == 0), 1'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) wr(3'd0, 32'($urandom_range(0, 15)));
            for (int k = 0; k < 3; k++) rd(3'($urandom_range(0, 7)));
            if (m_running) begin
                cu_finish = 1'b1; tick(); cu_finish = 1'b0;
            end
            if (m_releasing) tick();
            tick();
        end

        tick();
        tick();
        chk("pending_reads", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
